// File: rtl/datamemory_pkg.sv
// Shared definitions for the handshaked data memory: funct3 codes, FSM states,
// and helpers that decode access size, legality and alignment.
package datamemory_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_e;

    function automatic logic [3:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_size = 4'd1;
            F3_H, F3_HU: access_size = 4'd2;
            F3_W, F3_WU: access_size = 4'd4;
            F3_D:        access_size = 4'd8;
            default:     access_size = 4'd0;
        endcase
    endfunction

    // Doubleword and WU only exist on a 64-bit bank; stores have no unsigned forms.
    function automatic logic is_legal(input logic [2:0] funct3, input logic we, input logic wide);
        case (funct3)
            F3_D, F3_WU: is_legal = wide;
            3'b111:      is_legal = 1'b0;
            default:     is_legal = 1'b1;
        endcase
        if (we && funct3[2])
            is_legal = 1'b0;
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] low_addr);
        case (funct3)
            F3_H, F3_HU: is_aligned = (low_addr[0] == 1'b0);
            F3_W, F3_WU: is_aligned = (low_addr[1:0] == 2'b00);
            F3_D:        is_aligned = (low_addr == 3'b000);
            default:     is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/datamemory_hs_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
interface datamemory_hs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_bank_ram.sv
// Single-port synchronous RAM with byte enables and a registered, write-first read port.
module dm_bank_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    localparam int NBYTES = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [NBYTES-1:0] be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array or read register; a reset would block RAM inference.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i])
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            if (re)
                rdata[8*i +: 8] <= be[i] ? wdata[8*i +: 8] : mem[addr][8*i +: 8];
        end
    end

endmodule

// File: rtl/datamemory_hs.sv
// Handshaked MEM-stage data memory: one outstanding request, registered read path,
// misaligned/illegal accesses answered with an error response.
module datamemory_hs
    import datamemory_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic            clk,
    input  logic            reset_n,
    datamemory_hs_if.slave  bus,
    output logic            busy
);

    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int DEPTH  = 2 ** WORD_W;

    dm_state_e         state;
    logic [2:0]        ld_f3;
    logic [OFF_W-1:0]  ld_lane;

    logic [OFF_W-1:0]  lane;
    logic [3:0]        size;
    logic              acc_err;
    logic              accept;
    logic              store_go;
    logic              load_go;
    logic [NBYTES-1:0] be;
    logic [NBYTES-1:0] ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] fmt;

    assign lane     = bus.req_addr[OFF_W-1:0];
    assign size     = access_size(bus.req_funct3);
    assign acc_err  = !is_legal(bus.req_funct3, bus.req_we, DATA_W == 64)
                   || !is_aligned(bus.req_funct3, bus.req_addr[2:0]);
    assign accept   = (state == IDLE) && bus.req_valid;
    assign store_go = accept && bus.req_we && !acc_err;
    assign load_go  = accept && !bus.req_we && !acc_err;

    // NOTE: every always_comb output gets a default before any conditional update, so no latches.
    always_comb begin
        be = '0;
        for (int i = 0; i < NBYTES; i++)
            be[i] = (i >= int'(lane)) && (i < int'(lane) + int'(size));
    end

    assign ram_be    = store_go ? be : '0;
    assign ram_wdata = bus.req_wdata << {lane, 3'b000};

    dm_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .addr  (bus.req_addr[ADDR_W-1:OFF_W]),
        .wdata (ram_wdata),
        .re    (load_go),
        .rdata (ram_rdata)
    );

    // Load formatting uses the funct3/lane captured at accept; the requester may move on.
    assign shifted = ram_rdata >> {ld_lane, 3'b000};

    always_comb begin
        fmt = shifted;
        case (ld_f3)
            F3_B:    fmt = DATA_W'($signed(shifted[7:0]));
            F3_H:    fmt = DATA_W'($signed(shifted[15:0]));
            F3_W:    fmt = DATA_W'($signed(shifted[31:0]));
            F3_BU:   fmt = DATA_W'(shifted[7:0]);
            F3_HU:   fmt = DATA_W'(shifted[15:0]);
            F3_WU:   fmt = DATA_W'(shifted[31:0]);
            default: fmt = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            ld_f3         <= '0;
            ld_lane       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (acc_err || bus.req_we) begin
                            bus.rsp_rdata <= '0;
                            bus.rsp_err   <= acc_err;
                            state         <= RESP;
                        end else begin
                            ld_f3   <= bus.req_funct3;
                            ld_lane <= lane;
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    bus.rsp_rdata <= fmt;
                    bus.rsp_err   <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE);

endmodule
